// File: rtl/set_query_sched.sv
`default_nettype none
// set_query_sched (rev 1.0): FIFO-buffered query scheduler feeding a single SET engine.
// Optional macro SET_TIMEOUT_EN: a WAIT lasting 256 cycles returns res_count=8'hFF, res_err=1.
module set_query_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      in_central,
  input  logic [11:0]      in_radius,
  input  logic [1:0]       in_mode,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_count,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAG_W + 38;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [TAG_W-1:0] tag_ctr_q, cur_tag_q, res_tag_q;
  logic [23:0]      central_q;
  logic [11:0]      radius_q;
  logic [1:0]       mode_q;
  logic [7:0]       res_count_q;
  logic             push, pop, capture, timeout, fifo_empty;
  logic [EW-1:0]    head;

  assign in_ready    = (cnt_q != FULL_CNT);
  assign fifo_empty  = (cnt_q == '0);
  assign push        = in_valid & in_ready;
  assign head        = mem_q[rd_ptr_q];

  assign set_central = central_q;
  assign set_radius  = radius_q;
  assign set_mode    = mode_q;
  assign res_valid   = (state_q == RESP);
  assign res_count   = res_count_q;
  assign res_tag     = res_tag_q;

`ifdef SET_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       res_err_q;

  // wait_cnt_q == 255 marks the 256th WAIT cycle; a same-cycle set_valid still wins.
  assign timeout = (state_q == WAIT) && !set_valid && (wait_cnt_q == 8'hFF);
  assign res_err = res_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (set_en)
        wait_cnt_q <= '0;
      else if (state_q == WAIT)
        wait_cnt_q <= wait_cnt_q + 8'd1;
      if (capture)
        res_err_q <= 1'b0;
      else if (timeout)
        res_err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    set_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        if (!set_busy) begin
          set_en  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (set_valid) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            state_d = ISSUE;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {tag_ctr_q, in_mode, in_radius, in_central};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      tag_ctr_q   <= '0;
      cur_tag_q   <= '0;
      central_q   <= '0;
      radius_q    <= '0;
      mode_q      <= '0;
      res_count_q <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + AW'(1);
        tag_ctr_q <= tag_ctr_q + TAG_W'(1);
      end
      // Operands stay put from the pop until the next pop, covering the whole engine run.
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        {cur_tag_q, mode_q, radius_q, central_q} <= head;
      end
      if (push && !pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push)
        cnt_q <= cnt_q - (AW+1)'(1);
      if (capture || timeout) begin
        res_count_q <= capture ? set_candidate : 8'hFF;
        res_tag_q   <= cur_tag_q;
      end
    end
  end

endmodule
`default_nettype wire
